// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and frame geometry.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  localparam int UART_DEFAULT_CLKS_PER_BIT = 868;
  localparam int UART_DATA_BITS            = 8;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous input; RESET_VAL is the line's idle level.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: qualifies the start bit, strobes 8 mid-bit samples into
// an external LSB-first shift register, checks the stop bit and hands off via valid/ready.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic shift,
  output logic sipo_in,
  output logic rx_valid,
  input  logic rx_ready,
  output logic framing_err,
  output logic overrun_err,
  output logic busy
);

  localparam int              CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [2:0]       LAST_BIT = 3'(UART_DATA_BITS - 1);

  logic rxs;

  rx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic             shift_q, shift_d;
  logic             sipo_in_q, sipo_in_d;
  logic             rx_valid_q, rx_valid_d;
  logic             framing_q, framing_d;
  logic             overrun_q, overrun_d;
  logic             busy_q, busy_d;

  uart_sync2 #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d_i(rx),
    .q_o(rxs)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= 1'b0;
      sipo_in_q  <= 1'b0;
      rx_valid_q <= 1'b0;
      framing_q  <= 1'b0;
      overrun_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      sipo_in_q  <= sipo_in_d;
      rx_valid_q <= rx_valid_d;
      framing_q  <= framing_d;
      overrun_q  <= overrun_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = 1'b0;
    sipo_in_d  = 1'b0;
    framing_d  = 1'b0;
    overrun_d  = 1'b0;
    rx_valid_d = rx_valid_q;

    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (!rxs) begin
          cnt_d   = CNT_HALF;
          state_d = START;
        end
      end

      START: begin
        if (cnt_q == '0) begin
          if (!rxs) begin
            cnt_d     = CNT_FULL;
            bit_idx_d = '0;
            state_d   = DATA;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      DATA: begin
        if (cnt_q == '0) begin
          shift_d   = 1'b1;
          sipo_in_d = rxs;
          cnt_d     = CNT_FULL;
          // First strobe of a new frame overwrites the sipo: an unaccepted byte is lost here.
          if (bit_idx_q == '0 && rx_valid_q && !rx_ready) begin
            overrun_d  = 1'b1;
            rx_valid_d = 1'b0;
          end
          if (bit_idx_q == LAST_BIT) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      STOP: begin
        if (cnt_q == '0) begin
          if (rxs) begin
            rx_valid_d = 1'b1;
          end else begin
            framing_d = 1'b1;
          end
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign shift       = shift_q;
  assign sipo_in     = sipo_in_q;
  assign rx_valid    = rx_valid_q;
  assign framing_err = framing_q;
  assign overrun_err = overrun_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl at 8 clocks per bit, with a behavioural LSB-first sipo model.
module tb_uart_rx_ctrl;

  localparam int CPB = 8;

  logic clk = 1'b0;
  logic rst;
  logic rx;
  logic rx_ready;
  logic shift;
  logic sipo_in;
  logic rx_valid;
  logic framing_err;
  logic overrun_err;
  logic busy;

  int total = 0;
  int bad   = 0;

  int cycle = 0;
  int frameStart = 0;

  int       shiftCount = 0;
  int       shiftTime [0:127];
  logic     shiftBit  [0:127];
  logic [7:0] sipoModel = 8'h00;
  logic [7:0] sipoAtValid = 8'h00;
  int       framingCycles = 0;
  int       overrunCycles = 0;
  int       overrunWithStrobe = 0;
  int       validCycles = 0;
  int       validRises = 0;
  int       validRiseCycle = 0;
  logic     validPrev = 1'b0;
  int       busyCycles = 0;

  uart_rx_ctrl #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .shift      (shift),
    .sipo_in    (sipo_in),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .framing_err(framing_err),
    .overrun_err(overrun_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Observes DUT outputs away from the active edge and plays the role of the sipo.
  always @(negedge clk) begin
    if (shift) begin
      if (shiftCount < 128) begin
        shiftTime[shiftCount] <= cycle;
        shiftBit[shiftCount]  <= sipo_in;
      end
      shiftCount <= shiftCount + 1;
      sipoModel  <= {sipo_in, sipoModel[7:1]};
    end
    if (framing_err) framingCycles <= framingCycles + 1;
    if (overrun_err) begin
      overrunCycles <= overrunCycles + 1;
      if (shift && !rx_valid) overrunWithStrobe <= overrunWithStrobe + 1;
    end
    if (rx_valid) validCycles <= validCycles + 1;
    if (rx_valid && !validPrev) begin
      validRises     <= validRises + 1;
      validRiseCycle <= cycle;
      sipoAtValid    <= sipoModel;
    end
    validPrev <= rx_valid;
    if (busy) busyCycles <= busyCycles + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx = 1'b1;
    end
  endtask

  // Drives one 10-bit frame; readyIdx >= 0 raises rx_ready for exactly that bit-cycle index.
  task automatic applyStimulus(input logic [7:0] data, input logic stopBit, input int readyIdx);
    logic [9:0] frame;
    frame = {stopBit, data, 1'b0};
    for (int i = 0; i < 10 * CPB; i++) begin
      @(negedge clk);
      if (i == 0) frameStart = cycle;
      rx = frame[i / CPB];
      if (readyIdx >= 0) rx_ready = (i == readyIdx);
    end
  endtask

  function automatic logic [7:0] strobeByte(input int b);
    logic [7:0] v;
    for (int k = 0; k < 8; k++) v[k] = shiftBit[b + k];
    return v;
  endfunction

  function automatic int gapErrors(input int b);
    int e;
    e = 0;
    for (int k = 1; k < 8; k++) begin
      if (shiftTime[b + k] - shiftTime[b + k - 1] != CPB) e++;
    end
    return e;
  endfunction

  initial begin
    int sBase, fBase, oBase, owBase, vBase, vrBase, bBase;

    rst      = 1'b0;
    rx       = 1'b1;
    rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("resetOutputs", {26'd0, shift, sipo_in, rx_valid, framing_err, overrun_err, busy}, 32'd0);
    rst = 1'b1;
    idle(5);

    $display("[TB] clean frame 0xA5 with rx_ready held high");
    rx_ready = 1'b1;
    sBase = shiftCount; fBase = framingCycles; oBase = overrunCycles; vBase = validCycles;
    applyStimulus(8'hA5, 1'b1, -1);
    idle(20);
    checkOutput("a5Strobes", shiftCount - sBase, 8);
    checkOutput("a5Bits", strobeByte(sBase), 8'hA5);
    checkOutput("a5Spacing", gapErrors(sBase), 0);
    checkOutput("a5FirstStrobe", shiftTime[sBase] - frameStart, 2 + CPB / 2 + CPB + 1);
    checkOutput("a5ValidRise", validRiseCycle - frameStart, 2 + CPB / 2 + 9 * CPB + 1);
    checkOutput("a5Sipo", sipoAtValid, 8'hA5);
    checkOutput("a5ValidWidth", validCycles - vBase, 1);
    checkOutput("a5Errors", (framingCycles - fBase) + (overrunCycles - oBase), 0);

    $display("[TB] two-cycle start glitch");
    sBase = shiftCount; fBase = framingCycles; oBase = overrunCycles; bBase = busyCycles;
    @(negedge clk); rx = 1'b0;
    @(negedge clk); rx = 1'b0;
    idle(20);
    checkOutput("glitchStrobes", shiftCount - sBase, 0);
    checkOutput("glitchBusyCycles", busyCycles - bBase, CPB / 2);
    checkOutput("glitchErrors", (framingCycles - fBase) + (overrunCycles - oBase), 0);
    checkOutput("glitchIdle", busy, 0);

    $display("[TB] frame 0x3C with stop bit low");
    sBase = shiftCount; fBase = framingCycles; vBase = validCycles;
    applyStimulus(8'h3C, 1'b0, -1);
    idle(20);
    checkOutput("ferrStrobes", shiftCount - sBase, 8);
    checkOutput("ferrBits", strobeByte(sBase), 8'h3C);
    checkOutput("ferrPulse", framingCycles - fBase, 1);
    checkOutput("ferrNoValid", validCycles - vBase, 0);

    $display("[TB] back-to-back 0x11, 0x22 without accept");
    rx_ready = 1'b0;
    oBase = overrunCycles; owBase = overrunWithStrobe; vrBase = validRises;
    applyStimulus(8'h11, 1'b1, -1);
    checkOutput("b2bFirstValid", rx_valid, 1);
    applyStimulus(8'h22, 1'b1, -1);
    idle(10);
    checkOutput("b2bOverrun", overrunCycles - oBase, 1);
    checkOutput("b2bOverrunAtStrobe", overrunWithStrobe - owBase, 1);
    checkOutput("b2bValidRises", validRises - vrBase, 2);
    checkOutput("b2bSipo", sipoAtValid, 8'h22);
    checkOutput("b2bPending", rx_valid, 1);

    $display("[TB] accept coincident with first strobe");
    oBase = overrunCycles; vrBase = validRises;
    applyStimulus(8'h96, 1'b1, 2 + CPB / 2 + CPB);
    idle(10);
    checkOutput("accOverrun", overrunCycles - oBase, 0);
    checkOutput("accValidRises", validRises - vrBase, 1);
    checkOutput("accSipo", sipoAtValid, 8'h96);
    checkOutput("accPending", rx_valid, 1);
    rx_ready = 1'b1;
    idle(3);
    checkOutput("accCleared", rx_valid, 0);

    $display("[TB] reset after fourth strobe, then 0x5A");
    sBase = shiftCount;
    fork
      applyStimulus(8'hC3, 1'b1, -1);
      begin : waitRst
        int n;
        n = 0;
        while (shiftCount < sBase + 4 && n < 200) begin
          @(posedge clk);
          n++;
        end
        checkOutput("rstWait", shiftCount - sBase, 4);
        #2;
        checkOutput("busyBeforeRst", busy, 1);
        rst = 1'b0;
        #1;
        checkOutput("rstOutputs", {26'd0, shift, sipo_in, rx_valid, framing_err, overrun_err, busy}, 32'd0);
      end
    join
    checkOutput("rstNoStrobes", shiftCount - sBase, 4);
    idle(3);
    rst = 1'b1;
    idle(10);
    sBase = shiftCount; fBase = framingCycles; oBase = overrunCycles; vBase = validCycles;
    applyStimulus(8'h5A, 1'b1, -1);
    idle(20);
    checkOutput("postRstStrobes", shiftCount - sBase, 8);
    checkOutput("postRstSipo", sipoAtValid, 8'h5A);
    checkOutput("postRstValidWidth", validCycles - vBase, 1);
    checkOutput("postRstErrors", (framingCycles - fBase) + (overrunCycles - oBase), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
